seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised, self-timed successor to the combinational 8-digit 7-segment mux.
- Contains its own refresh prescaler and digit-scan counter, so no external Control counter is needed.
- Adds per-digit enable, decimal points, PWM brightness and configurable output polarity.
- Display data is double-buffered and swapped only on frame boundaries, so a frame never shows a mix of old and new values. Sits between the datapath/BCD decoders and the board anode/segment pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16)
REFRESH_LOG2, 17, log2 of clocks per digit slot (>= BRIGHT_W)
BRIGHT_W, 3, brightness control width
AN_ACTIVE_LOW, 1, 1 = anode outputs active-low (common-anode board)
SEG_ACTIVE_LOW, 1, 1 = segment and dp outputs active-low

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
seg_in  in  7*N_DIGITS  segment patterns, digit k at [7k+6:7k], bit=1 means lit
dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
digit_en  in  N_DIGITS  per-digit enable, 0 = digit dark
brightness  in  BRIGHT_W  duty level, 0 = off, max = (2^BRIGHT_W-1)/2^BRIGHT_W
load  in  1  one-cycle strobe: capture seg_in/dp_in/digit_en
load_ack  out  1  one-cycle pulse when captured data becomes active
AA  out  N_DIGITS  anode drive
segment  out  7  segment drive, bit0 = segment a
dp  out  1  decimal point drive
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Synchronous, active-low reset on clk.
- Reset state:
  - prescaler = 0, digit index = 0, pending flag = 0.
  - Active and pending buffers = 0.
  - AA = all inactive, segment = all inactive, dp = inactive (polarity applied).
  - load_ack = 0, frame_done = 0.
- Prescaler counts 0..2^REFRESH_LOG2-1 and wraps freely. slot_end = (prescaler == all-ones).
- Digit index advances on slot_end; from N_DIGITS-1 it wraps to 0 (non-power-of-2 N_DIGITS supported).
  - frame_end = slot_end AND index == N_DIGITS-1.
  - frame_done = frame_end registered: one cycle wide, one pulse per N_DIGITS*2^REFRESH_LOG2 clocks.
- Digit lit condition (internal, active-high): all of
  - active digit_en[index] = 1;
  - prescaler top BRIGHT_W bits < brightness;
  - not the first prescaler count of the slot (prescaler != 0). This is the anti-ghost blank.
- When lit: only anode[index] active; segment and dp from the active buffer for that index.
- When not lit: all anodes and all segments inactive.
- A disabled digit still consumes its slot, so frame rate and brightness stay constant.
- brightness is sampled live, with no buffering.
- Outputs are registered: exactly 1 clock latency from prescaler/index state to pins.
- Polarity: AA = internal XOR {N{AN_ACTIVE_LOW}}; segment and dp likewise with SEG_ACTIVE_LOW.
- Load handshake:
  - load=1 captures the inputs into the pending buffer and sets pending. A new load while pending overwrites pending data (latest wins).
  - At frame_end:
    - if load=1 the same cycle, the inputs go directly to the active buffer (bypass);
    - else if pending, the pending buffer goes to the active buffer.
  - Either case: pending cleared, load_ack=1 on the next cycle.
  - No load and no pending: the active buffer holds and load_ack stays 0.
  - The active buffer never changes except at frame_end.
- Reset asserted mid-scan: the next cycle reaches the reset state and discards pending data. Scanning restarts at digit 0 with a blank display until the first load is applied.

Test Plan:
(N_DIGITS=8, REFRESH_LOG2=4, BRIGHT_W=2, active-low; slot=16 clk, frame=128 clk)
- Reset, then load with seg_in digit k = 7'h01<<(k%7), dp_in=8'h81, digit_en=8'hFF, brightness=3 -> load_ack exactly at end of the first frame (cycle 128 after reset release). Next frame: AA = ~(1<<k) during counts 1..11 of slot k; segment matches; dp low only for digits 0 and 7; all off at counts 0 and 12..15.
- brightness=1 -> each digit active 3 clocks per 16-clock slot (counts 1..3). brightness=0 -> AA=8'hFF throughout.
- digit_en=8'b1010_1010 -> slots 0,2,4,6 fully dark; frame_done period still 128 clocks.
- load issued mid-frame with new data, then a second load 5 clocks later -> the old pattern persists to frame end. The second data set becomes active next frame; single load_ack.
- load coincident with the frame_end cycle, pending from an earlier load -> coincident data wins; one load_ack.
- Reset (reset=0) asserted mid-slot 5 for 1 clk -> the next cycle AA=8'hFF, segment=7'h7F, index restarts at 0, previous data not shown until a new load.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Load/data bus between the datapath and the display scan controller.
// The master presents segment data and strobes load; the slave returns load_ack.
interface seg7_scan_ctrl_if #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned BRIGHT_W = 3
);
  logic [7*N_DIGITS-1:0] seg_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic [BRIGHT_W-1:0]   brightness;
  logic                  load;
  logic                  load_ack;

  modport master (
    output seg_in,
    output dp_in,
    output digit_en,
    output brightness,
    output load,
    input  load_ack
  );

  modport slave (
    input  seg_in,
    input  dp_in,
    input  digit_en,
    input  brightness,
    input  load,
    output load_ack
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Self-timed multi-digit 7-segment scanner with per-digit enable, decimal points,
// PWM brightness, configurable pin polarity and frame-synchronous double buffering.
module seg7_scan_ctrl #(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned REFRESH_LOG2   = 17,
  parameter int unsigned BRIGHT_W       = 3,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_ctrl_if.slave     bus,
  output logic [N_DIGITS-1:0] AA,
  output logic [6:0]          segment,
  output logic                dp,
  output logic                frame_done
);

  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] AnPol  = {N_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]          SegPol = {7{SEG_ACTIVE_LOW}};

  logic [REFRESH_LOG2-1:0] presc_q;
  logic [IdxW-1:0]         idx_q;

  logic [7*N_DIGITS-1:0]   act_seg_q, pend_seg_q;
  logic [N_DIGITS-1:0]     act_dp_q, pend_dp_q;
  logic [N_DIGITS-1:0]     act_en_q, pend_en_q;
  logic                    pend_q;

  logic [N_DIGITS-1:0]     aa_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    ack_q;
  logic                    frame_done_q;

  logic                    slot_end;
  logic                    frame_end;
  logic                    lit;
  logic [BRIGHT_W-1:0]     duty_pos;
  logic [N_DIGITS-1:0]     an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  assign slot_end  = &presc_q;
  assign frame_end = slot_end && (idx_q == IdxW'(N_DIGITS - 1));
  assign duty_pos  = presc_q[REFRESH_LOG2-1 -: BRIGHT_W];

  // Count 0 of every slot is forced dark so the previous digit cannot ghost into this one.
  assign lit = act_en_q[idx_q] && (duty_pos < bus.brightness) && (presc_q != '0);

  always_comb begin
    an_d  = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (lit) begin
      an_d[idx_q] = 1'b1;
      seg_d       = act_seg_q[7*idx_q +: 7];
      dp_d        = act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_seg_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_seg_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_q       <= 1'b0;
      aa_q         <= AnPol;
      seg_q        <= SegPol;
      dp_q         <= SEG_ACTIVE_LOW;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q <= presc_q + 1'b1;
      if (slot_end) begin
        idx_q <= (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end

      if (bus.load) begin
        pend_seg_q <= bus.seg_in;
        pend_dp_q  <= bus.dp_in;
        pend_en_q  <= bus.digit_en;
        pend_q     <= 1'b1;
      end

      ack_q <= 1'b0;
      // A load landing on the frame boundary bypasses the pending buffer and wins.
      if (frame_end) begin
        if (bus.load) begin
          act_seg_q <= bus.seg_in;
          act_dp_q  <= bus.dp_in;
          act_en_q  <= bus.digit_en;
        end else if (pend_q) begin
          act_seg_q <= pend_seg_q;
          act_dp_q  <= pend_dp_q;
          act_en_q  <= pend_en_q;
        end
        ack_q  <= bus.load || pend_q;
        pend_q <= 1'b0;
      end

      frame_done_q <= frame_end;
      aa_q         <= an_d ^ AnPol;
      seg_q        <= seg_d ^ SegPol;
      dp_q         <= dp_d ^ SEG_ACTIVE_LOW;
    end
  end

  assign AA           = aa_q;
  assign segment      = seg_q;
  assign dp           = dp_q;
  assign frame_done   = frame_done_q;
  assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: loads are scored into a queue of expected
// activation cycles; a negedge monitor checks every pin every cycle.
module tb_seg7_scan_ctrl;
  localparam int unsigned N     = 8;
  localparam int unsigned RL    = 4;
  localparam int unsigned BW    = 2;
  localparam int unsigned SLOT  = 16;
  localparam int unsigned FRAME = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] AA;
  logic [6:0]   segment;
  logic         dp;
  logic         frame_done;

  seg7_scan_ctrl_if #(.N_DIGITS(N), .BRIGHT_W(BW)) bus ();

  seg7_scan_ctrl #(
    .N_DIGITS      (N),
    .REFRESH_LOG2  (RL),
    .BRIGHT_W      (BW),
    .AN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .AA        (AA),
    .segment   (segment),
    .dp        (dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      cyc;
    logic [7*N-1:0]   seg;
    logic [N-1:0]     dpv;
    logic [N-1:0]     en;
  } load_t;

  load_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int unsigned   cyc = 0;
  logic          rst_s = 1'b0;
  logic          started = 1'b0;
  logic [BW-1:0] br_s = '0;

  // Display contents the bench believes are active
  logic [7*N-1:0] m_seg = '0;
  logic [N-1:0]   m_dp = '0;
  logic [N-1:0]   m_en = '0;

  int unsigned p, k;
  logic        lit_e, ack_e, dp_e;
  logic [N-1:0] aa_e;
  logic [6:0]   seg_e;

  always @(posedge clk) begin
    started <= 1'b1;
    rst_s   <= reset;
    br_s    <= bus.brightness;
    cyc     <= reset ? cyc + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cyc %0d", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (!rst_s) begin
        exp_q.delete();
        m_seg = '0;
        m_dp  = '0;
        m_en  = '0;
        chk("rst_aa", AA, {N{1'b1}});
        chk("rst_seg", segment, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_ack", bus.load_ack, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
      end else begin
        ack_e = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          ack_e = 1'b1;
          m_seg = exp_q[0].seg;
          m_dp  = exp_q[0].dpv;
          m_en  = exp_q[0].en;
          void'(exp_q.pop_front());
        end
        chk("load_ack", bus.load_ack, ack_e);
        chk("frame_done", frame_done, (cyc % FRAME) == 0);
        p     = (cyc - 1) % SLOT;
        k     = ((cyc - 1) / SLOT) % N;
        lit_e = m_en[k] && ((p >> (RL - BW)) < br_s) && (p != 0);
        aa_e  = lit_e ? ~(N'(1) << k) : {N{1'b1}};
        seg_e = lit_e ? ~m_seg[7*k +: 7] : 7'h7F;
        dp_e  = lit_e ? ~m_dp[k] : 1'b1;
        chk("aa", AA, aa_e);
        chk("segment", segment, seg_e);
        chk("dp", dp, dp_e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load is sampled at edge cyc+1 and becomes active at the next multiple of FRAME.
  task automatic do_load(input logic [7*N-1:0] s, input logic [N-1:0] d, input logic [N-1:0] e);
    load_t ent;
    ent.cyc = (cyc / FRAME + 1) * FRAME;
    ent.seg = s;
    ent.dpv = d;
    ent.en  = e;
    if (exp_q.size() > 0 && exp_q[$].cyc == ent.cyc) exp_q[$] = ent;
    else exp_q.push_back(ent);
    bus.seg_in   = s;
    bus.dp_in    = d;
    bus.digit_en = e;
    bus.load     = 1'b1;
    step(1);
    bus.load     = 1'b0;
  endtask

  task automatic wait_mod(input int unsigned r);
    for (int i = 0; i < 300; i++) begin
      if (cyc % FRAME == r) return;
      step(1);
    end
    chk("wait_timeout", cyc % FRAME, r);
  endtask

  logic [7*N-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;

  initial begin
    for (int i = 0; i < N; i++) begin
      pat_a[7*i +: 7] = 7'h01 << (i % 7);
      pat_b[7*i +: 7] = ~(7'h01 << (i % 7));
      pat_c[7*i +: 7] = 7'h40 >> (i % 7);
      pat_d[7*i +: 7] = 7'(i + 3);
      pat_e[7*i +: 7] = 7'(7'h55 ^ 7'(i));
      pat_f[7*i +: 7] = 7'h7F;
    end
    bus.seg_in     = '0;
    bus.dp_in      = '0;
    bus.digit_en   = '0;
    bus.brightness = 2'd3;
    bus.load       = 1'b0;
    reset          = 1'b0;
    step(3);
    reset = 1'b1;

    // Full brightness, all digits
    step(10);
    do_load(pat_a, 8'h81, 8'hFF);
    step(300);

    // Reduced and zero brightness
    bus.brightness = 2'd1;
    step(FRAME);
    bus.brightness = 2'd0;
    step(FRAME);
    bus.brightness = 2'd3;

    // Alternate digits disabled
    do_load(pat_a, 8'h81, 8'b1010_1010);
    step(2 * FRAME);

    // Two loads in one frame: latest wins, single ack
    wait_mod(40);
    do_load(pat_b, 8'h0F, 8'hFF);
    step(4);
    do_load(pat_c, 8'h18, 8'hFF);
    step(FRAME + 20);

    // Pending load overridden by a load on the frame_end cycle
    wait_mod(60);
    do_load(pat_d, 8'h3C, 8'hFF);
    wait_mod(FRAME - 1);
    do_load(pat_e, 8'hC3, 8'h7F);
    step(FRAME + 10);

    // One-clock reset mid slot 5 discards pending data
    wait_mod(84);
    do_load(pat_f, 8'hFF, 8'hFF);
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(FRAME + 10);
    do_load(pat_a, 8'h81, 8'hFF);
    step(FRAME + 20);

    chk("ack_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
